// File: rtl/osd_pkg.sv
// Shared widths, pixel/tap types and arithmetic helpers for the OSD overlay mixer.
package osd_pkg;

  localparam int PIX_W     = 24;
  localparam int CH_W      = 8;
  localparam int ALPHA_W   = 8;
  localparam int A_W       = ALPHA_W + 1;
  localparam int PROD_W    = CH_W + A_W;
  localparam int FADE_STEP = 16;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic osd_de;
    rgb_t rgb;
  } vid_tap_t;

  // Maps 0..255 onto 0..256 so that 255 selects the overlay colour exactly.
  function automatic logic [A_W-1:0] eff_alpha(input logic [ALPHA_W-1:0] alpha);
    return {1'b0, alpha} + {{(A_W-1){1'b0}}, alpha[ALPHA_W-1]};
  endfunction

  function automatic logic [ALPHA_W-1:0] fade_step(input logic [ALPHA_W-1:0] cur,
                                                   input logic [ALPHA_W-1:0] tgt);
    logic [ALPHA_W-1:0] res;
    if (cur < tgt) begin
      res = ((tgt - cur) > ALPHA_W'(FADE_STEP)) ? (cur + ALPHA_W'(FADE_STEP)) : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > ALPHA_W'(FADE_STEP)) ? (cur - ALPHA_W'(FADE_STEP)) : tgt;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/osd_blend_channel.sv
// One colour channel of the alpha blend: weighted products, then sum and scale.
module osd_blend_channel
  import osd_pkg::*;
(
  input  logic            pixel_clk,
  input  logic            rst,
  input  logic [CH_W-1:0] osd_c,
  input  logic [CH_W-1:0] vid_c,
  input  logic [A_W-1:0]  a,
  input  logic            valid,
  output logic [CH_W-1:0] out_c
);

  logic [A_W-1:0]    a_inv_s;
  logic [PROD_W-1:0] p_r;
  logic [PROD_W-1:0] q_r;
  logic              valid_r;

  assign a_inv_s = 9'd256 - a;

  // Stage 1: overlay and video weighted by complementary alphas.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      p_r     <= 17'd0;
      q_r     <= 17'd0;
      valid_r <= 1'b0;
    end else begin
      p_r     <= PROD_W'(osd_c) * PROD_W'(a);
      q_r     <= PROD_W'(vid_c) * PROD_W'(a_inv_s);
      valid_r <= valid;
    end
  end

  // Stage 2: normalise by 256; blanked pixels are forced black.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      out_c <= 8'd0;
    end else if (valid_r) begin
      out_c <= CH_W'((p_r + q_r) >> 8);
    end else begin
      out_c <= 8'd0;
    end
  end

endmodule

// File: rtl/osd_overlay_mixer.sv
// Aligns overlay colour with live video, alpha-blends, and re-emits delayed syncs.
// Optional per-frame fade in/out is enabled by defining OSD_FADE_EN.
module osd_overlay_mixer
  import osd_pkg::*;
#(
  parameter int OSD_LATENCY = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               vs_in,
  input  logic               hs_in,
  input  logic               de_in,
  input  logic [CH_W-1:0]    r_in,
  input  logic [CH_W-1:0]    g_in,
  input  logic [CH_W-1:0]    b_in,
  input  logic               osd_de,
  input  logic [PIX_W-1:0]   osd_data,
  input  logic [ALPHA_W-1:0] osd_alpha,
  input  logic               osd_enable,
  output logic               vs_out,
  output logic               hs_out,
  output logic               de_out,
  output logic [CH_W-1:0]    r_out,
  output logic [CH_W-1:0]    g_out,
  output logic [CH_W-1:0]    b_out
);

  vid_tap_t           tap_in_s;
  vid_tap_t           tap_d_s;
  vid_tap_t           dly_r [OSD_LATENCY];
  logic [2:0]         sync_r [PIPE_STAGES];
  rgb_t               osd_rgb_s;
  logic               vs_prev_r;
  logic               vs_rise_s;
  logic               en_frame_r;
  logic               en_eff_s;
  logic [ALPHA_W-1:0] alpha_src_s;
  logic [A_W-1:0]     a_s;

  assign tap_in_s  = '{vs: vs_in, hs: hs_in, de: de_in, osd_de: osd_de,
                       rgb: '{r: r_in, g: g_in, b: b_in}};
  assign tap_d_s   = dly_r[OSD_LATENCY-1];
  assign osd_rgb_s = rgb_t'(osd_data);
  assign vs_rise_s = vs_in & ~vs_prev_r;

  // Delay video and window flag so each pixel meets its own overlay colour.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OSD_LATENCY; i++) dly_r[i] <= '0;
    end else begin
      dly_r[0] <= tap_in_s;
      for (int i = 1; i < OSD_LATENCY; i++) dly_r[i] <= dly_r[i-1];
    end
  end

  // Latch the overlay request once per frame on the vs rising edge.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vs_prev_r  <= 1'b0;
      en_frame_r <= 1'b0;
    end else begin
      vs_prev_r <= vs_in;
      if (vs_rise_s) en_frame_r <= osd_enable;
    end
  end

`ifdef OSD_FADE_EN
  logic [ALPHA_W-1:0] fade_r;

  // Move the fade level one step per frame toward the requested opacity.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      fade_r <= 8'd0;
    end else if (vs_rise_s) begin
      fade_r <= fade_step(fade_r, osd_enable ? osd_alpha : 8'd0);
    end
  end

  // A nonzero level keeps the overlay live so a fade-out runs to completion.
  assign alpha_src_s = fade_r;
  assign en_eff_s    = en_frame_r | (fade_r != 8'd0);
`else
  assign alpha_src_s = osd_alpha;
  assign en_eff_s    = en_frame_r;
`endif

  // Effective weight of the overlay for the pixel leaving the delay line.
  always_comb begin
    a_s = 9'd0;
    if (en_eff_s && tap_d_s.osd_de) begin
      a_s = eff_alpha(alpha_src_s);
    end else begin
      a_s = 9'd0;
    end
  end

  osd_blend_channel u_blend_r (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .osd_c     (osd_rgb_s.r),
    .vid_c     (tap_d_s.rgb.r),
    .a         (a_s),
    .valid     (tap_d_s.de),
    .out_c     (r_out)
  );

  osd_blend_channel u_blend_g (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .osd_c     (osd_rgb_s.g),
    .vid_c     (tap_d_s.rgb.g),
    .a         (a_s),
    .valid     (tap_d_s.de),
    .out_c     (g_out)
  );

  osd_blend_channel u_blend_b (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .osd_c     (osd_rgb_s.b),
    .vid_c     (tap_d_s.rgb.b),
    .a         (a_s),
    .valid     (tap_d_s.de),
    .out_c     (b_out)
  );

  // Syncs follow the blend pipeline; PIPE_STAGES must equal the blend depth.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) sync_r[i] <= 3'b000;
    end else begin
      sync_r[0] <= {tap_d_s.vs, tap_d_s.hs, tap_d_s.de};
      for (int i = 1; i < PIPE_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign {vs_out, hs_out, de_out} = sync_r[PIPE_STAGES-1];

endmodule

// File: tb/tb_osd_overlay_mixer.sv
// Directed bench: reset, opaque/partial blends, frame latch, blanking, sync latency (L=1 and L=3).
module tb_osd_overlay_mixer;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic        vs_in, hs_in, de_in;
  logic [7:0]  r_in, g_in, b_in;
  logic        osd_de;
  logic [23:0] osd_data;
  logic [7:0]  osd_alpha;
  logic        osd_enable;
  logic        vs1, hs1, de1, vs3, hs3, de3;
  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic [26:0] obs1, obs3;
  logic [23:0] pend_oc;
  logic [7:0]  pend_oa;
  int          n_pass, n_tot;

  always #5 pixel_clk = ~pixel_clk;

  osd_overlay_mixer #(.OSD_LATENCY(1)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .osd_de(osd_de), .osd_data(osd_data),
    .osd_alpha(osd_alpha), .osd_enable(osd_enable), .vs_out(vs1), .hs_out(hs1),
    .de_out(de1), .r_out(r1), .g_out(g1), .b_out(b1));

  osd_overlay_mixer #(.OSD_LATENCY(3)) dut3 (
    .pixel_clk(pixel_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .osd_de(osd_de), .osd_data(osd_data),
    .osd_alpha(osd_alpha), .osd_enable(osd_enable), .vs_out(vs3), .hs_out(hs3),
    .de_out(de3), .r_out(r3), .g_out(g3), .b_out(b3));

  assign obs1 = {vs1, hs1, de1, r1, g1, b1};
  assign obs3 = {vs3, hs3, de3, r3, g3, b3};

  // One pixel per call; overlay colour/alpha arrive one cycle after their pixel (L=1).
  task automatic step(input logic v, input logic h, input logic d, input logic [23:0] vid,
                      input logic od, input logic [23:0] oc, input logic [7:0] oa);
    osd_data  = pend_oc;
    osd_alpha = pend_oa;
    pend_oc   = oc;
    pend_oa   = oa;
    vs_in = v; hs_in = h; de_in = d;
    {r_in, g_in, b_in} = vid;
    osd_de = od;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
  endtask

  task automatic win(input logic [23:0] vid, input logic [23:0] oc, input logic [7:0] oa);
    step(1'b0, 1'b0, 1'b1, vid, 1'b1, oc, oa);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(); idle();
    n_tot++; if (obs1 !== 27'h0) $display("FAIL reset_l1 got %h want %h", obs1, 27'h0); else n_pass++;
    n_tot++; if (obs3 !== 27'h0) $display("FAIL reset_l3 got %h want %h", obs3, 27'h0); else n_pass++;
    rst = 1'b0;
    osd_enable = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
    win(24'h102030, 24'hFFFFFF, 8'hFF);
    rst = 1'b1;
    #1;
    n_tot++; if (obs1 !== 27'h0) $display("FAIL reset_async got %h want %h", obs1, 27'h0); else n_pass++;
    idle();
    n_tot++; if (obs1 !== 27'h0) $display("FAIL reset_hold got %h want %h", obs1, 27'h0); else n_pass++;
    rst = 1'b0;
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'h102030}) $display("FAIL reset_overlay_off got %h want %h", obs1, {3'b001, 24'h102030}); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'hFFFFFF}) $display("FAIL reset_overlay_back got %h want %h", obs1, {3'b001, 24'hFFFFFF}); else n_pass++;
  endtask

  task automatic test_opaque();
    osd_enable = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
    win(24'h102030, 24'hFFFFFF, 8'hFF);
    n_tot++; if (obs1 !== {3'b100, 24'h0}) $display("FAIL opaque_vs_lat got %h want %h", obs1, {3'b100, 24'h0}); else n_pass++;
    step(1'b0, 1'b0, 1'b1, 24'h102030, 1'b0, 24'h000000, 8'hFF);
    n_tot++; if (obs1 !== 27'h0) $display("FAIL opaque_early got %h want %h", obs1, 27'h0); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b001, 24'hFFFFFF}) $display("FAIL opaque_in got %h want %h", obs1, {3'b001, 24'hFFFFFF}); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b001, 24'h102030}) $display("FAIL opaque_out got %h want %h", obs1, {3'b001, 24'h102030}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    win(24'h0000FF, 24'hFF0000, 8'd128);
    win(24'h204080, 24'h804020, 8'd64);
    win(24'h123456, 24'hFFFFFF, 8'd0);
    n_tot++; if (obs1 !== {3'b001, 24'h80007E}) $display("FAIL half_blend got %h want %h", obs1, {3'b001, 24'h80007E}); else n_pass++;
    win(24'hF0F0F0, 24'h0A0B0C, 8'd255);
    n_tot++; if (obs1 !== {3'b001, 24'h384068}) $display("FAIL quarter_blend got %h want %h", obs1, {3'b001, 24'h384068}); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b001, 24'h123456}) $display("FAIL alpha0 got %h want %h", obs1, {3'b001, 24'h123456}); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b001, 24'h0A0B0C}) $display("FAIL alpha255 got %h want %h", obs1, {3'b001, 24'h0A0B0C}); else n_pass++;
    idle();
  endtask

  task automatic test_frame_latch();
    osd_enable = 1'b0;
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'hFFFFFF}) $display("FAIL latch_persist got %h want %h", obs1, {3'b001, 24'hFFFFFF}); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'h102030}) $display("FAIL latch_off got %h want %h", obs1, {3'b001, 24'h102030}); else n_pass++;
    osd_enable = 1'b1;
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'h102030}) $display("FAIL latch_midframe_on got %h want %h", obs1, {3'b001, 24'h102030}); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    osd_enable = 1'b0;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
    win(24'h102030, 24'hFFFFFF, 8'hFF); idle(); idle();
    n_tot++; if (obs1 !== {3'b001, 24'hFFFFFF}) $display("FAIL latch_vs_high got %h want %h", obs1, {3'b001, 24'hFFFFFF}); else n_pass++;
    osd_enable = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'h0);
    idle();
  endtask

  task automatic test_blanking();
    idle(); idle();
    step(1'b0, 1'b1, 1'b0, 24'h112233, 1'b1, 24'hFFFFFF, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 24'h445566, 1'b0, 24'h000000, 8'hFF);
    n_tot++; if (obs1 !== 27'h0) $display("FAIL sync_early got %h want %h", obs1, 27'h0); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b010, 24'h0}) $display("FAIL blank_rgb got %h want %h", obs1, {3'b010, 24'h0}); else n_pass++;
    idle();
    n_tot++; if (obs1 !== {3'b101, 24'h445566}) $display("FAIL sync_l1 got %h want %h", obs1, {3'b101, 24'h445566}); else n_pass++;
    n_tot++; if ({vs3, hs3, de3} !== 3'b000) $display("FAIL sync_l3_early got %b want %b", {vs3, hs3, de3}, 3'b000); else n_pass++;
    idle();
    n_tot++; if ({vs3, hs3, de3} !== 3'b010) $display("FAIL sync_l3_a got %b want %b", {vs3, hs3, de3}, 3'b010); else n_pass++;
    idle();
    n_tot++; if ({vs3, hs3, de3} !== 3'b101) $display("FAIL sync_l3_b got %b want %b", {vs3, hs3, de3}, 3'b101); else n_pass++;
    idle();
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    rst = 1'b1;
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
    osd_de = 1'b0; osd_data = 24'h0; osd_alpha = 8'h0; osd_enable = 1'b0;
    pend_oc = 24'h0; pend_oa = 8'h0;
    test_reset();
    test_opaque();
    test_back_to_back();
    test_frame_latch();
    test_blanking();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
